// File: rtl/pcie_rx_pkg.sv
// rtl/pcie_rx_pkg.sv - shared widths and beat layout for the PCIe RX stream adapter
package pcie_rx_pkg;

   localparam int RX_DATA_W = 128;
   localparam int RX_BEAT_W = 156;

   typedef struct packed {
      logic [RX_DATA_W-1:0] data;
      logic [15:0]          be;
      logic [7:0]           bardec;
      logic                 sop;
      logic                 eop;
      logic                 empty;
      logic                 err;
   } rx_beat_t;

endpackage

// File: rtl/pcie_rx_fifo.sv
// rtl/pcie_rx_fifo.sv - single-clock FIFO with registered show-ahead read port
module pcie_rx_fifo
   import pcie_rx_pkg::*;
#(
   parameter int DEPTH = 8
)(
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       wr_en,
   input  logic [RX_BEAT_W-1:0]       wr_data,
   input  logic                       rd_en,
   output logic [RX_BEAT_W-1:0]       rd_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [RX_BEAT_W-1:0] mem [DEPTH];
   logic [AW-1:0]        wr_ptr;
   logic [AW-1:0]        rd_ptr;
   logic [AW-1:0]        rd_ptr_next;
   logic [CW-1:0]        count_next;
   logic                 rd_ok;
   logic                 wr_ok;

   assign full        = (count == CW'(DEPTH));
   assign empty       = (count == '0);
   assign rd_ok       = rd_en && !empty;
   assign wr_ok       = wr_en && (!full || rd_ok);
   assign count_next  = count + CW'(wr_ok) - CW'(rd_ok);
   assign rd_ptr_next = rd_ptr + AW'(rd_ok);

   always_ff @(posedge clk) begin
      if (wr_ok)
         mem[wr_ptr] <= wr_data;
   end

   // rd_data always holds the head entry; an empty FIFO bypasses the write straight to it
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         rd_data <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(wr_ok);
         rd_ptr <= rd_ptr_next;
         count  <= count_next;
         if (wr_ok && (count - CW'(rd_ok)) == '0)
            rd_data <= wr_data;
         else if (count_next != '0)
            rd_data <= mem[rd_ptr_next];
      end
   end

endmodule

// File: rtl/pcie_rx_st_adapter.sv
// rtl/pcie_rx_st_adapter.sv - hard-IP RX ready-latency absorber, BAR hold, framing/overflow flags
// Optional statistics counters are built when PCIE_RX_STATS_EN is defined.
module pcie_rx_st_adapter
   import pcie_rx_pkg::*;
#(
   parameter int DEPTH   = 8,
   parameter int RDY_LAT = 3
)(
   input  logic                 ava_clk,
   input  logic                 ava_rst,
   input  logic                 rx_st_valid,
   input  logic [RX_DATA_W-1:0] rx_st_data,
   input  logic                 rx_st_sop,
   input  logic                 rx_st_eop,
   input  logic                 rx_st_empty,
   input  logic                 rx_st_err,
   input  logic [7:0]           rx_st_bardec,
   input  logic [15:0]          rx_st_be,
   output logic                 rx_st_ready,
   output logic                 rx_st_mask,
   input  logic                 np_hold,
   output logic                 m_valid,
   input  logic                 m_ready,
   output logic [RX_DATA_W-1:0] m_data,
   output logic [15:0]          m_be,
   output logic                 m_sop,
   output logic                 m_eop,
   output logic                 m_empty,
   output logic                 m_err,
   output logic [7:0]           m_bardec,
   output logic                 overflow,
   output logic                 framing_err,
   output logic [31:0]          tlp_cnt,
   output logic [31:0]          stall_cnt
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] READY_THRESH = CW'(DEPTH - RDY_LAT - 1);

   rx_beat_t      in_beat;
   rx_beat_t      out_beat;
   logic [7:0]    bar_hold;
   logic          in_pkt;
   logic          fifo_full;
   logic          fifo_empty;
   logic [CW-1:0] fifo_count;
   logic [CW-1:0] occ_next;
   logic          rd;
   logic          wr_ok;

   always_comb begin
      in_beat        = '0;
      in_beat.data   = rx_st_data;
      in_beat.be     = rx_st_be;
      in_beat.bardec = rx_st_sop ? rx_st_bardec : bar_hold;
      in_beat.sop    = rx_st_sop;
      in_beat.eop    = rx_st_eop;
      in_beat.empty  = rx_st_empty;
      in_beat.err    = rx_st_err;
   end

   pcie_rx_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk     (ava_clk),
      .rst     (ava_rst),
      .wr_en   (rx_st_valid),
      .wr_data (in_beat),
      .rd_en   (rd),
      .rd_data (out_beat),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   assign m_valid  = !fifo_empty;
   assign rd       = m_valid && m_ready;
   assign wr_ok    = rx_st_valid && (!fifo_full || rd);
   assign occ_next = fifo_count + CW'(wr_ok) - CW'(rd);

   assign m_data   = out_beat.data;
   assign m_be     = out_beat.be;
   assign m_bardec = out_beat.bardec;
   assign m_sop    = out_beat.sop;
   assign m_eop    = out_beat.eop;
   assign m_empty  = out_beat.empty;
   assign m_err    = out_beat.err;

   // The hard IP keeps sending for RDY_LAT cycles after ready drops, so ready looks ahead
   always_ff @(posedge ava_clk) begin
      if (ava_rst) begin
         rx_st_ready <= 1'b0;
         rx_st_mask  <= 1'b0;
         bar_hold    <= '0;
         in_pkt      <= 1'b0;
         overflow    <= 1'b0;
         framing_err <= 1'b0;
      end else begin
         rx_st_ready <= (occ_next <= READY_THRESH);
         rx_st_mask  <= np_hold;
         if (rx_st_valid) begin
            if (rx_st_sop)
               bar_hold <= rx_st_bardec;
            if (rx_st_eop)
               in_pkt <= 1'b0;
            else if (rx_st_sop)
               in_pkt <= 1'b1;
            if ((rx_st_sop && in_pkt) || (!rx_st_sop && !in_pkt))
               framing_err <= 1'b1;
            if (!wr_ok)
               overflow <= 1'b1;
         end
      end
   end

`ifdef PCIE_RX_STATS_EN
   always_ff @(posedge ava_clk) begin
      if (ava_rst) begin
         tlp_cnt   <= '0;
         stall_cnt <= '0;
      end else begin
         if (wr_ok && rx_st_eop)
            tlp_cnt <= tlp_cnt + 32'd1;
         if (!rx_st_ready)
            stall_cnt <= stall_cnt + 32'd1;
      end
   end
`else
   assign tlp_cnt   = '0;
   assign stall_cnt = '0;
`endif

endmodule

// File: doc/pcie_rx_st_adapter.md
# pcie_rx_st_adapter

Receive-side stage directly downstream of the Stratix IV PCIe hard-IP wrapper's Avalon-ST RX port (`rx_st_*0`, 128-bit, Gen2 x4). It absorbs the hard IP's fixed ready latency in a small FIFO. It re-presents the stream to application logic on a zero-latency valid/ready interface, holding each TLP's BAR decode for every beat. It also drives the non-posted mask and flags framing errors and overflow.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; power of two; must be ≥ `RDY_LAT`+3.
- `RDY_LAT`, 3: cycles from an `rx_st_ready` sample to the hard IP's corresponding `rx_st_valid`.

Ports:
- `ava_clk`  in  1: Avalon 125 MHz core clock (`ava_core_clk_out`).
- `ava_rst`  in  1: reset, synchronous, active-high.
- `rx_st_valid`  in  1: beat valid from the hard IP.
- `rx_st_data`  in  128: beat data.
- `rx_st_sop` / `rx_st_eop`  in  1 each: start / end of packet.
- `rx_st_empty`  in  1: upper 64 bits empty; meaningful on eop only.
- `rx_st_err`  in  1: ECC/uncorrectable error flag.
- `rx_st_bardec`  in  8: BAR hit one-hot; meaningful on sop only.
- `rx_st_be`  in  16: byte enables.
- `rx_st_ready`  out  1: to the hard IP `rx_st_ready0`.
- `rx_st_mask`  out  1: to the hard IP `rx_st_mask0`.
- `np_hold`  in  1: application request to hold off non-posted TLPs.
- `m_valid`  out  1 / `m_ready`  in  1: downstream handshake.
- `m_data` 128, `m_be` 16, `m_sop`, `m_eop`, `m_empty`, `m_err` 1 each, `m_bardec` 8  out: downstream beat.
- `overflow`  out  1: sticky; a beat arrived while the FIFO was full.
- `framing_err`  out  1: sticky; SOP/EOP sequence violated.
- `tlp_cnt`  out  32, `stall_cnt`  out  32: statistics (see Configuration).

## Operation
- FIFO entry width is 156 bits: data, be, bardec, sop, eop, empty, err.
- A beat is written when `rx_st_valid`=1. `rx_st_ready` is never used to qualify the write.
- A beat is read when `m_valid && m_ready`. Simultaneous write and read leaves occupancy unchanged.
- `rx_st_ready` register: next value = (occupancy after the current cycle ≤ `DEPTH`−`RDY_LAT`−1). Default threshold is 4.
- Full and write in the same cycle: the beat is dropped and `overflow` sets. A simultaneous read frees the slot, so the write succeeds.
- BAR hold: on a sop write, `rx_st_bardec` is latched into an input-side register. That register is written into the entry for every beat until and including eop. `m_bardec` is therefore constant across a TLP.
- Framing tracker (input side), `in_pkt` flag:
  - sop while `in_pkt`=1 sets `framing_err`.
  - A non-sop beat while `in_pkt`=0 sets `framing_err`.
  - A beat with both sop and eop is legal (single-beat TLP) and leaves `in_pkt`=0.
- `rx_st_mask` = `np_hold` registered one cycle.
- Overflow and framing errors do not halt the data path; beats keep flowing.

## Timing
- Reset values:
  - `rx_st_ready`=0, `rx_st_mask`=0, `m_valid`=0.
  - All other `m_*` outputs = 0.
  - `overflow`=0, `framing_err`=0, counters=0, FIFO empty, `in_pkt`=0.
- First cycle after reset deassertion: `rx_st_ready`=1.
- Latency: a beat written in cycle t is presented on `m_*` in cycle t+1 if the FIFO was empty. Outputs come from the FIFO's registered read port.
- `m_valid` is held with all `m_*` stable until `m_ready`.
- Pointers wrap modulo `DEPTH`. Occupancy is log2(`DEPTH`)+1 bits.
- Reset mid-packet: the FIFO is flushed and in-flight beats are lost. Beats arriving before `rx_st_ready` rises are still written.

## Configuration
- `PCIE_RX_STATS_EN` defined:
  - `tlp_cnt` increments on every accepted eop write.
  - `stall_cnt` increments each cycle `rx_st_ready`=0 outside reset.
  - Both counters wrap at 2^32.
- Undefined: both outputs are tied to 0 and no counter logic is built.

## Structure
- Package `pcie_rx_pkg` holds:
  - constant `RX_DATA_W`=128 and constant `RX_BEAT_W`=156;
  - the packed beat typedef `rx_beat_t`.
- Sub-module `pcie_rx_fifo`: synchronous single-clock FIFO, parameter `DEPTH`, width `RX_BEAT_W`, with registered read, `full`, `empty` and `count`.
- Ready computation, BAR hold, framing tracking and counters live in the top level.

## Test plan
- Back-to-back 3-beat TLP, `bardec`=8'h04 on sop, `m_ready`=1: the three beats emerge in order one cycle later, `m_bardec`=8'h04 on all three, no errors.
- `m_ready`=0 with continuous input and `RDY_LAT`=3 honoured: `rx_st_ready` falls once occupancy exceeds 4, FIFO peaks ≤ 8, `overflow` stays 0. Release `m_ready`: all beats drain intact.
- Hard IP ignores ready (valid continues beyond 8 beats with `m_ready`=0): the 9th beat is dropped, `overflow`=1 and remains 1.
- sop,sop without eop, then a lone data beat: `framing_err`=1 after the second sop; data still forwarded.
- Assert `ava_rst` mid-packet with 5 beats buffered: next cycle `m_valid`=0 and `rx_st_ready`=0; after release, `rx_st_ready`=1 and the FIFO is empty.
- With `PCIE_RX_STATS_EN`: 10 TLPs plus 7 ready-low cycles give `tlp_cnt`=10 and `stall_cnt`=7. Without the macro, both read 0.
